// File: rtl/button_event_gen.sv
// Turns the debounced button level into single-cycle press/release/long/repeat events,
// a held level and a wrapping press counter. Define BUTTON_REPEAT_EN to enable auto-repeat.
module button_event_gen #(
   parameter int CNT_W             = 24,
   parameter int LONG_PRESS_CYCLES = 12500000,
   parameter int REPEAT_CYCLES     = 2500000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       btn_in,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] press_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

   if ((LONG_PRESS_CYCLES < 2) || (REPEAT_CYCLES < 2)) begin : g_bad_cycles
      $error("button_event_gen: cycle parameters must be at least 2");
   end

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;
   logic             long_pulse_q, long_pulse_d;
   logic             held_q, held_d;
   logic [7:0]       press_count_q, press_count_d;
   logic             rise, fall;

`ifdef BUTTON_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             repeat_pulse_q, repeat_pulse_d;
`endif

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

   // Next-state and next-output logic; a fall always wins over a long/repeat threshold.
   always_comb begin
      state_d         = state_q;
      hold_cnt_d      = hold_cnt_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      long_pulse_d    = 1'b0;
      held_d          = held_q;
      press_count_d   = press_count_q;
`ifdef BUTTON_REPEAT_EN
      rep_cnt_d       = rep_cnt_q;
      repeat_pulse_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (rise) begin
               press_pulse_d = 1'b1;
               held_d        = 1'b1;
               press_count_d = press_count_q + 8'd1;
               hold_cnt_d    = '0;
               state_d       = PRESSED;
            end else begin
               state_d = IDLE;
            end
         end
         PRESSED: begin
            if (fall) begin
               release_pulse_d = 1'b1;
               held_d          = 1'b0;
               hold_cnt_d      = '0;
               state_d         = IDLE;
            end else if (hold_cnt_q == LONG_LAST) begin
               long_pulse_d = 1'b1;
               hold_cnt_d   = '0;
`ifdef BUTTON_REPEAT_EN
               rep_cnt_d    = '0;
`endif
               state_d      = HELD;
            end else begin
               hold_cnt_d = hold_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         HELD: begin
            if (fall) begin
               release_pulse_d = 1'b1;
               held_d          = 1'b0;
               hold_cnt_d      = '0;
`ifdef BUTTON_REPEAT_EN
               rep_cnt_d       = '0;
`endif
               state_d         = IDLE;
`ifdef BUTTON_REPEAT_EN
            end else if (rep_cnt_q == REP_LAST) begin
               repeat_pulse_d = 1'b1;
               rep_cnt_d      = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`else
            end else begin
               state_d = HELD;
            end
`endif
         end
         default: begin
            state_d    = IDLE;
            held_d     = 1'b0;
            hold_cnt_d = '0;
`ifdef BUTTON_REPEAT_EN
            rep_cnt_d  = '0;
`endif
         end
      endcase
   end

   // Synchronizer, FSM state, counters and registered outputs; clr discards everything.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync1_q         <= 1'b0;
         sync2_q         <= 1'b0;
         prev_q          <= 1'b0;
         state_q         <= IDLE;
         hold_cnt_q      <= '0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;
         held_q          <= 1'b0;
         press_count_q   <= 8'd0;
`ifdef BUTTON_REPEAT_EN
         rep_cnt_q       <= '0;
         repeat_pulse_q  <= 1'b0;
`endif
      end else begin
         sync1_q         <= btn_in;
         sync2_q         <= sync1_q;
         prev_q          <= sync2_q;
         state_q         <= state_d;
         hold_cnt_q      <= hold_cnt_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_pulse_q    <= long_pulse_d;
         held_q          <= held_d;
         press_count_q   <= press_count_d;
`ifdef BUTTON_REPEAT_EN
         rep_cnt_q       <= rep_cnt_d;
         repeat_pulse_q  <= repeat_pulse_d;
`endif
      end
   end

   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_pulse    = long_pulse_q;
   assign held          = held_q;
   assign press_count   = press_count_q;
`ifdef BUTTON_REPEAT_EN
   assign repeat_pulse  = repeat_pulse_q;
`else
   assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Directed self-checking bench for button_event_gen (LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4).
`timescale 1ns/1ps
module tb_button_event_gen;

   logic       clk = 1'b0;
   logic       clr;
   logic       btn_in;
   logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
   logic [7:0] press_count;

   int n_cmp = 0;
   int n_err = 0;
   int n_press = 0, n_release = 0, n_long = 0, n_repeat = 0, n_multi = 0;

   button_event_gen #(
      .CNT_W(8),
      .LONG_PRESS_CYCLES(8),
      .REPEAT_CYCLES(4)
   ) dut (
      .clk(clk),
      .clr(clr),
      .btn_in(btn_in),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .long_pulse(long_pulse),
      .repeat_pulse(repeat_pulse),
      .held(held),
      .press_count(press_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock: wait past the edge, then tally the pulses the DUT just registered.
   task automatic tick();
      int ones;
      @(posedge clk);
      #1;
      ones = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
      if (ones > 1) n_multi++;
      if (press_pulse === 1'b1) n_press++;
      if (release_pulse === 1'b1) n_release++;
      if (long_pulse === 1'b1) n_long++;
      if (repeat_pulse === 1'b1) n_repeat++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq(tag, {27'd0, press_pulse, release_pulse, long_pulse, repeat_pulse, held}, 32'd0);
      check_eq(tag, {24'd0, press_count}, 32'd0);
   endtask

   initial begin
      int p0, r0, l0, q0;
      logic exp_rep;

      // Reset with button released
      clr = 1'b1;
      btn_in = 1'b0;
      tick();
      check_idle_outputs("reset_c1");
      tick();
      check_idle_outputs("reset_c2");
      clr = 1'b0;
      ticks(2);
      check_idle_outputs("idle_after_reset");

      // Short press of 5 cycles: 3-edge latency on both edges, no long_pulse
      l0 = n_long;
      btn_in = 1'b1;
      tick();
      check_eq("short_e0_press", {31'd0, press_pulse}, 32'd0);
      tick();
      check_eq("short_e1_press", {31'd0, press_pulse}, 32'd0);
      tick();
      check_eq("short_e2_press", {31'd0, press_pulse}, 32'd1);
      check_eq("short_e2_held", {31'd0, held}, 32'd1);
      check_eq("short_e2_count", {24'd0, press_count}, 32'd1);
      tick();
      check_eq("short_e3_press", {31'd0, press_pulse}, 32'd0);
      tick();
      btn_in = 1'b0;
      tick();
      check_eq("short_f0_release", {31'd0, release_pulse}, 32'd0);
      tick();
      check_eq("short_f1_release", {31'd0, release_pulse}, 32'd0);
      tick();
      check_eq("short_f2_release", {31'd0, release_pulse}, 32'd1);
      check_eq("short_f2_held", {31'd0, held}, 32'd0);
      tick();
      check_eq("short_f3_release", {31'd0, release_pulse}, 32'd0);
      ticks(8);
      check_eq("short_no_long", n_long - l0, 32'd0);

      // 20-cycle hold: long at +8, repeats at +12/+16, fall at +20 suppresses the third repeat
      btn_in = 1'b1;
      ticks(3);
      check_eq("hold_press", {31'd0, press_pulse}, 32'd1);
      check_eq("hold_count", {24'd0, press_count}, 32'd2);
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k == 17) btn_in = 1'b0;
`ifdef BUTTON_REPEAT_EN
         exp_rep = (k == 12) || (k == 16);
`else
         exp_rep = 1'b0;
`endif
         check_eq($sformatf("hold_k%0d_long", k), {31'd0, long_pulse}, {31'd0, (k == 8)});
         check_eq($sformatf("hold_k%0d_repeat", k), {31'd0, repeat_pulse}, {31'd0, exp_rep});
         check_eq($sformatf("hold_k%0d_release", k), {31'd0, release_pulse}, {31'd0, (k == 20)});
         check_eq($sformatf("hold_k%0d_held", k), {31'd0, held}, {31'd0, (k < 20)});
      end
      ticks(3);

      // Fall reaches the FSM on the very edge hold_cnt hits its threshold
      l0 = n_long;
      btn_in = 1'b1;
      ticks(3);
      check_eq("race_press", {31'd0, press_pulse}, 32'd1);
      ticks(5);
      btn_in = 1'b0;
      ticks(2);
      check_eq("race_k7_held", {31'd0, held}, 32'd1);
      tick();
      check_eq("race_k8_release", {31'd0, release_pulse}, 32'd1);
      check_eq("race_k8_long", {31'd0, long_pulse}, 32'd0);
      ticks(12);
      check_eq("race_no_long", n_long - l0, 32'd0);
      check_eq("race_count", {24'd0, press_count}, 32'd3);

      // 256 short presses from a cleared counter wrap back to 0
      clr = 1'b1;
      ticks(2);
      clr = 1'b0;
      ticks(2);
      p0 = n_press;
      r0 = n_release;
      l0 = n_long;
      for (int i = 0; i < 256; i++) begin
         btn_in = 1'b1;
         ticks(4);
         btn_in = 1'b0;
         ticks(4);
         if (i == 254) check_eq("wrap_255", {24'd0, press_count}, 32'd255);
      end
      check_eq("wrap_0", {24'd0, press_count}, 32'd0);
      check_eq("wrap_presses", n_press - p0, 32'd256);
      check_eq("wrap_releases", n_release - r0, 32'd256);
      check_eq("wrap_no_long", n_long - l0, 32'd0);

      // clr mid-HELD with button still down, then a fresh press and a 20-cycle hold
      btn_in = 1'b1;
      ticks(3);
      check_eq("midheld_press", {31'd0, press_pulse}, 32'd1);
      ticks(10);
      check_eq("midheld_held", {31'd0, held}, 32'd1);
      clr = 1'b1;
      tick();
      check_idle_outputs("midheld_clr_c1");
      tick();
      check_idle_outputs("midheld_clr_c2");
      clr = 1'b0;
      tick();
      check_eq("reclr_e0_press", {31'd0, press_pulse}, 32'd0);
      tick();
      check_eq("reclr_e1_press", {31'd0, press_pulse}, 32'd0);
      tick();
      check_eq("reclr_e2_press", {31'd0, press_pulse}, 32'd1);
      check_eq("reclr_count", {24'd0, press_count}, 32'd1);
      l0 = n_long;
      q0 = n_repeat;
      ticks(20);
      check_eq("reclr_long", n_long - l0, 32'd1);
`ifdef BUTTON_REPEAT_EN
      check_eq("reclr_repeats", n_repeat - q0, 32'd3);
`else
      check_eq("reclr_repeats", n_repeat - q0, 32'd0);
`endif
      btn_in = 1'b0;
      ticks(3);
      check_eq("reclr_release", {31'd0, release_pulse}, 32'd1);
      ticks(2);

      check_eq("one_hot_pulses", n_multi, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
